// File: rtl/control_unit_staged.sv
`default_nettype none
// ============================================================================
// control_unit_staged : RV32I/M decode registered into D->E, divide busy FSM.
// Optional macro CU_RV32M_EN enables M-extension decode.       Rev 1.0
// ============================================================================
module control_unit_staged #(
  parameter int ALU_CTRL_W  = 4,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  stall_in,
  input  logic                  flush_in,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcE,
  output logic                  MemWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            funct3E,
  output logic                  MulDivE,
  output logic                  IllegalE,
  output logic                  busy
);

  if (ALU_CTRL_W < 4 || DIV_LATENCY < 2 || (1 << CNT_W) <= DIV_LATENCY) begin : g_param_check
    $error("control_unit_staged: illegal parameter combination");
  end

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_ialu  = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  localparam logic [3:0] c_alu_add   = 4'b0000;
  localparam logic [3:0] c_alu_sub   = 4'b0001;
  localparam logic [3:0] c_alu_and   = 4'b0010;
  localparam logic [3:0] c_alu_or    = 4'b0011;
  localparam logic [3:0] c_alu_xor   = 4'b0100;
  localparam logic [3:0] c_alu_slt   = 4'b0101;
  localparam logic [3:0] c_alu_sltu  = 4'b0110;
  localparam logic [3:0] c_alu_sll   = 4'b0111;
  localparam logic [3:0] c_alu_srl   = 4'b1000;
  localparam logic [3:0] c_alu_sra   = 4'b1001;
  localparam logic [3:0] c_alu_passb = 4'b1010;
`ifdef CU_RV32M_EN
  localparam logic [3:0] c_alu_mul   = 4'b1011;
  localparam logic [3:0] c_alu_div   = 4'b1100;
`endif

  typedef struct packed {
    logic       rw;
    logic       srca;
    logic       asrc;
    logic       mw;
    logic [1:0] rs;
    logic       br;
    logic       jmp;
    logic [3:0] alu;
    logic [2:0] f3;
    logic       md;
    logic       ill;
  } ctrl_t;

  ctrl_t      w_dec;
  ctrl_t      r_e;
  logic [2:0] w_imm;
  logic       w_hold;
  logic       w_busy_hold;
`ifdef CU_RV32M_EN
  logic       w_is_div;
  logic       w_div_start;
`endif

  // alt selects SRA over SRL; sub_ok limits SUB to register-register ops
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'b000:  alu_op = (alt && sub_ok) ? c_alu_sub : c_alu_add;
      3'b001:  alu_op = c_alu_sll;
      3'b010:  alu_op = c_alu_slt;
      3'b011:  alu_op = c_alu_sltu;
      3'b100:  alu_op = c_alu_xor;
      3'b101:  alu_op = alt ? c_alu_sra : c_alu_srl;
      3'b110:  alu_op = c_alu_or;
      default: alu_op = c_alu_and;
    endcase
  endfunction

  always_comb begin
    w_dec    = '0;
    w_dec.f3 = funct3;
    w_imm    = c_imm_i;
`ifdef CU_RV32M_EN
    w_is_div = 1'b0;
`endif
    case (Op)
      c_op_load:  begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_dec.rs = 2'b01; end
      c_op_store: begin w_dec.mw = 1'b1; w_dec.asrc = 1'b1; w_imm = c_imm_s; end
      c_op_rtype: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          w_dec.rw  = 1'b1;
          w_dec.alu = alu_op(funct3, funct7[5], 1'b1);
        end
`ifdef CU_RV32M_EN
        else if (funct7 == 7'b0000001) begin
          w_dec.rw  = 1'b1;
          w_dec.md  = 1'b1;
          w_dec.alu = funct3[2] ? c_alu_div : c_alu_mul;
          w_is_div  = funct3[2];
        end
`endif
        else begin
          w_dec.ill = 1'b1;
        end
      end
      c_op_ialu: begin
        w_dec.rw   = 1'b1;
        w_dec.asrc = 1'b1;
        w_dec.alu  = alu_op(funct3, funct7[5], 1'b0);
      end
      c_op_br:    begin w_dec.br = 1'b1; w_imm = c_imm_b; w_dec.alu = c_alu_sub; end
      c_op_jal: begin
        w_dec.rw = 1'b1; w_dec.jmp = 1'b1; w_dec.rs = 2'b10;
        w_dec.srca = 1'b1; w_dec.asrc = 1'b1; w_imm = c_imm_j;
      end
      c_op_jalr:  begin w_dec.rw = 1'b1; w_dec.jmp = 1'b1; w_dec.rs = 2'b10; w_dec.asrc = 1'b1; end
      c_op_lui:   begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_imm = c_imm_u; w_dec.alu = c_alu_passb; end
      c_op_auipc: begin w_dec.rw = 1'b1; w_dec.srca = 1'b1; w_dec.asrc = 1'b1; w_imm = c_imm_u; end
      default:    w_dec.ill = 1'b1;
    endcase
  end

  assign ImmSrcD = w_imm;
  // the last BUSY cycle (counter 0) already lets the next instruction in
  assign w_hold  = stall_in || w_busy_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_e <= '0;
    else if (flush_in)    r_e <= '0;
    else if (!w_hold)     r_e <= instr_valid ? w_dec : '0;
  end

`ifdef CU_RV32M_EN
  localparam logic [0:0]       c_st_idle  = 1'b0;
  localparam logic [0:0]       c_st_busy  = 1'b1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(DIV_LATENCY - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  assign busy        = (r_state == c_st_busy);
  assign w_busy_hold = busy && (r_cnt != '0);
  assign w_div_start = !flush_in && !w_hold && instr_valid && w_is_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else if (flush_in) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else if (w_div_start) begin
      r_state <= c_st_busy;
      r_cnt   <= c_cnt_init;
    end else if (r_state == c_st_busy) begin
      if (r_cnt == '0) r_state <= c_st_idle;
      else             r_cnt   <= r_cnt - CNT_W'(1);
    end
  end
`else
  assign busy        = 1'b0;
  assign w_busy_hold = 1'b0;
`endif

  assign RegWriteE   = r_e.rw;
  assign ALUSrcAE    = r_e.srca;
  assign ALUSrcE     = r_e.asrc;
  assign MemWriteE   = r_e.mw;
  assign ResultSrcE  = r_e.rs;
  assign BranchE     = r_e.br;
  assign JumpE       = r_e.jmp;
  assign ALUControlE = ALU_CTRL_W'(r_e.alu);
  assign funct3E     = r_e.f3;
  assign MulDivE     = r_e.md;
  assign IllegalE    = r_e.ill;

endmodule
`default_nettype wire

// File: tb/tb_control_unit_staged.sv
`default_nettype none
// Directed bench for control_unit_staged; divide sequencing covered when CU_RV32M_EN is defined.
module tb_control_unit_staged;
  localparam int ALU_W = 4;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  logic clk = 1'b0, rst = 1'b0, instr_valid = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
  logic [6:0] Op = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [2:0] ImmSrcD, funct3E;
  logic RegWriteE, ALUSrcAE, ALUSrcE, MemWriteE, BranchE, JumpE, MulDivE, IllegalE, busy;
  logic [1:0] ResultSrcE;
  logic [ALU_W-1:0] ALUControlE;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  control_unit_staged #(.ALU_CTRL_W(ALU_W), .DIV_LATENCY(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .Op(Op), .funct3(funct3), .funct7(funct7),
    .stall_in(stall_in), .flush_in(flush_in), .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE), .funct3E(funct3E),
    .MulDivE(MulDivE), .IllegalE(IllegalE), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    instr_valid = v; Op = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("reset_rw", RegWriteE, 0);
    chk("reset_alu", ALUControlE, 0);
    chk("reset_rs", ResultSrcE, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ill", IllegalE, 0);
    #12 rst = 1'b1;
    @(negedge clk);

    drive(1, OP_R, 3'b000, 7'b0000000);
    #1 chk("add_latency", RegWriteE, 0);
    tick;
    chk("add_alu", ALUControlE, 4'b0000);
    chk("add_rw", RegWriteE, 1);
    drive(1, OP_R, 3'b000, 7'b0100000);
    tick;
    chk("sub_alu", ALUControlE, 4'b0001);

    drive(1, OP_LOAD, 3'b010, 7'b0);
    #1 chk("lw_imm", ImmSrcD, 3'b000);
    tick;
    chk("lw_rs", ResultSrcE, 2'b01);
    chk("lw_asrc", ALUSrcE, 1);
    drive(1, OP_STORE, 3'b010, 7'b0);
    #1 chk("sw_imm", ImmSrcD, 3'b001);
    tick;
    chk("sw_mw", MemWriteE, 1);
    chk("sw_rw", RegWriteE, 0);
    drive(1, OP_BR, 3'b000, 7'b0);
    #1 chk("beq_imm", ImmSrcD, 3'b010);
    tick;
    chk("beq_br", BranchE, 1);
    chk("beq_alu", ALUControlE, 4'b0001);
    drive(1, OP_JAL, 3'b000, 7'b0);
    #1 chk("jal_imm", ImmSrcD, 3'b011);
    tick;
    chk("jal_jump", JumpE, 1);
    chk("jal_rs", ResultSrcE, 2'b10);
    chk("jal_srca", ALUSrcAE, 1);
    drive(1, OP_LUI, 3'b000, 7'b0);
    #1 chk("lui_imm", ImmSrcD, 3'b100);
    tick;
    chk("lui_alu", ALUControlE, 4'b1010);
    drive(1, OP_I, 3'b101, 7'b0100000);
    tick;
    chk("srai_alu", ALUControlE, 4'b1001);
    chk("srai_asrc", ALUSrcE, 1);
    drive(1, OP_I, 3'b000, 7'b0100000);
    tick;
    chk("addi_no_sub", ALUControlE, 4'b0000);
    drive(1, OP_R, 3'b011, 7'b0000000);
    tick;
    chk("sltu_alu", ALUControlE, 4'b0110);
    chk("sltu_f3e", funct3E, 3'b011);

    drive(1, OP_R, 3'b100, 7'b0000000);
    stall_in = 1'b1;
    tick;
    chk("stall_hold", ALUControlE, 4'b0110);
    flush_in = 1'b1;
    tick;
    chk("stall_flush_rw", RegWriteE, 0);
    chk("stall_flush_f3", funct3E, 0);
    stall_in = 1'b0; flush_in = 1'b0;
    tick;
    chk("xor_alu", ALUControlE, 4'b0100);
    drive(0, OP_R, 3'b100, 7'b0000000);
    tick;
    chk("bubble_rw", RegWriteE, 0);
    chk("bubble_alu", ALUControlE, 0);

    drive(1, OP_BAD, 3'b010, 7'b0);
    #1 chk("bad_imm", ImmSrcD, 3'b000);
    tick;
    chk("bad_ill", IllegalE, 1);
    chk("bad_rw", RegWriteE, 0);
    drive(1, OP_R, 3'b000, 7'b0000010);
    tick;
    chk("badf7_ill", IllegalE, 1);
    chk("badf7_rw", RegWriteE, 0);

    drive(1, OP_R, 3'b000, 7'b0000000);
    tick;
    #2 rst = 1'b0;
    #1 chk("async_rst_rw", RegWriteE, 0);
    #1 rst = 1'b1;
    @(negedge clk);

`ifdef CU_RV32M_EN
    drive(1, OP_R, 3'b000, 7'b0000001);
    tick;
    chk("mul_alu", ALUControlE, 4'b1011);
    chk("mul_md", MulDivE, 1);
    chk("mul_busy", busy, 0);
    drive(1, OP_R, 3'b100, 7'b0000001);
    tick;
    drive(1, OP_R, 3'b000, 7'b0000000);
    chk("div_busy_0", busy, 1);
    chk("div_alu", ALUControlE, 4'b1100);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("div_busy_n", busy, 1);
      chk("div_md_held", MulDivE, 1);
    end
    tick;
    chk("div_exit_busy", busy, 0);
    chk("div_exit_add", ALUControlE, 4'b0000);
    chk("div_exit_rw", RegWriteE, 1);

    drive(1, OP_R, 3'b110, 7'b0000001);
    tick;
    drive(1, OP_R, 3'b111, 7'b0000001);
    for (int i = 1; i < 8; i++) tick;
    chk("b2b_last", busy, 1);
    tick;
    chk("b2b_reenter", busy, 1);
    chk("b2b_f3e", funct3E, 3'b111);
    drive(1, OP_R, 3'b000, 7'b0000000);
    tick; tick;
    flush_in = 1'b1;
    tick;
    flush_in = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_rw", RegWriteE, 0);
    chk("flush_md", MulDivE, 0);

    drive(1, OP_R, 3'b101, 7'b0000001);
    tick;
    drive(1, OP_R, 3'b000, 7'b0000000);
    tick;
    chk("rdiv_busy", busy, 1);
    #2 rst = 1'b0;
    #1 chk("rdiv_busy0", busy, 0);
    chk("rdiv_md0", MulDivE, 0);
    chk("rdiv_alu0", ALUControlE, 0);
    #1 rst = 1'b1;
    @(negedge clk);
`else
    drive(1, OP_R, 3'b000, 7'b0000001);
    tick;
    chk("nomul_ill", IllegalE, 1);
    chk("nomul_rw", RegWriteE, 0);
    chk("nomul_md", MulDivE, 0);
    drive(1, OP_R, 3'b100, 7'b0000001);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("nodiv_busy", busy, 0);
    end
    chk("nodiv_ill", IllegalE, 1);
    drive(1, OP_R, 3'b000, 7'b0000000);
    tick;
    chk("nodiv_next_add", RegWriteE, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
